dm_responder: RTL and testbench
===============================

# dm_responder

Multi-cycle data-memory responder for the MIPS core. Services the core's `memRead`/`memWrite` requests from an internal word array after a parameterised number of wait states. While a request is pending it drives `stall`, which holds the PC and the register window. It pulses `ready` with registered read data when the access completes. It replaces the zero-latency data memory inside the datapath and sits between the control unit's memory strobes and the datapath's write-back mux.

## Interface
- `WIDTH`, 8: data word width in bits.
- `ADDR_W`, 8: address width; array depth is 2**ADDR_W words.
- `LATENCY`, 2: wait states per access, legal range 0..15.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `memRead`  in  1: read request from the control unit; held until `ready`.
- `memWrite`  in  1: write request from the control unit; held until `ready`.
- `addr`  in  ADDR_W: word address; held stable with the request.
- `wrData`  in  WIDTH: write data; held stable with the request.
- `rdData`  out  WIDTH: read data, registered; valid while `ready`=1.
- `ready`  out  1: one-cycle completion pulse.
- `stall`  out  1: combinational; holds PC/`ldWnd`/`regWrite` while high.
- `err`  out  1: sticky; set when a request asserts both strobes.

## Operation
- FSM states: IDLE, BUSY, RESP. Counter `cnt` is 4 bits.
- IDLE:
  - `memRead` xor `memWrite` high → capture `addr`, `wrData` and kind.
  - If LATENCY=0 → RESP; else load `cnt`=LATENCY → BUSY.
  - Both strobes high → set `err`, stay IDLE, no access, `stall`=0.
  - No strobe → stay IDLE.
- BUSY: if `cnt`=1 → RESP; else decrement `cnt`. Input changes during BUSY are ignored; captured values are used.
- Array access happens on the edge entering RESP:
  - Write: array[addr_q] ← wrData_q; `rdData` unchanged.
  - Read: `rdData` ← array[addr_q].
- RESP: `ready`=1, `stall`=0 → IDLE unconditionally. Request lines still showing the old instruction during RESP are not re-sampled, so there is no double issue.
- `stall` = (IDLE and exactly one strobe) or BUSY.
- Array contents are not reset. Reads of never-written words return X in simulation.
- Arithmetic: `cnt` counts down only and never wraps. The address is used unmodified; no bounds check is needed because depth is 2**ADDR_W.

## Timing
- Request first visible in cycle t (IDLE):
  - `stall`=1 in cycles t..t+LATENCY.
  - `ready`=1 and `rdData` valid in cycle t+LATENCY+1.
  - Next request is accepted in cycle t+LATENCY+2 at the earliest.
- A memory instruction occupies LATENCY+2 cycles. Non-memory instructions cause no stall.
- Reset values: state=IDLE, `cnt`=0, `rdData`=0, `ready`=0, `stall`=0, `err`=0.
- Reset asserted mid-access (BUSY or RESP): return to IDLE immediately. A pending write is dropped, the array is untouched, and `ready` does not pulse.
- `err` clears only on reset.
- Back-to-back writes then a read to the same address: the read returns the last written value; no bypass is needed because the accesses are serialised.

## Structure
- Shared package `mips_pkg`: state encodings IDLE=2'b00, BUSY=2'b01, RESP=2'b10; default `WIDTH`/`ADDR_W` constants.
- Sub-module `dm_array`: synchronous single-port array with `we`, `re`, `addr`, `din`, `dout` (registered). FSM and counter live in `dm_responder`.

## Test plan
- Reset: hold `rst`=0 with strobes toggling → `ready`=0, `stall`=0, `rdData`=0, `err`=0 throughout.
- LATENCY=2: write 8'hA5 to 8'h10 in cycle t → `stall` high t..t+2, `ready` at t+3. Read 8'h10 at t+4 → `ready` at t+7 with `rdData`=8'hA5.
- LATENCY=0: read request in cycle t → `stall` only in t, `ready` at t+1. Back-to-back writes 8'h01 and 8'h02 to addresses 3 and 4 → reads return 8'h01 and 8'h02.
- Both strobes high with addr 8'h20 → `err`=1 (sticky), `stall`=0, no `ready`. Subsequent read of 8'h20 returns its prior contents.
- Reset pulled low in BUSY of a write of 8'h77 to 8'h05 → no `ready`. After reset, read 8'h05 returns its pre-write value.
- Change `addr`/`wrData` during BUSY → the originally captured address/data are used.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core memory-side blocks.
// Contents: data-memory responder state encoding and default widths.
package mips_pkg;

  localparam int unsigned DM_WIDTH  = 8;
  localparam int unsigned DM_ADDR_W = 8;
  localparam int unsigned DM_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } dm_state_e;

endpackage : mips_pkg

// File: rtl/dm_array.sv
// Synchronous single-port word array with registered read data.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset (clears dout only)
//   we   - write enable: mem[addr] <= din
//   re   - read enable: dout <= mem[addr]
//   addr - word address
//   din  - write data
//   dout - registered read data, holds between reads
module dm_array
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH  = DM_WIDTH,
  parameter int unsigned ADDR_W = DM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= din;
    end
  end

  // Read port register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dout <= '0;
    end else if (re) begin
      r_dout <= r_mem[addr];
    end
  end

  assign dout = r_dout;

endmodule : dm_array

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: serves memRead/memWrite from an
// internal array after LATENCY wait states, stalling the core meanwhile.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   memRead, memWrite - request strobes, held until ready
//   addr, wrData      - request address / write data
//   rdData            - registered read data, valid while ready
//   ready             - one-cycle completion pulse
//   stall             - combinational hold for PC / register window
//   err               - sticky: both strobes seen together
module dm_responder
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH   = DM_WIDTH,
  parameter int unsigned ADDR_W  = DM_ADDR_W,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wrData,
  output logic [WIDTH-1:0]  rdData,
  output logic              ready,
  output logic              stall,
  output logic              err
);

  dm_state_e             r_state;
  dm_state_e             w_next;
  logic [DM_CNT_W-1:0]   r_cnt;
  logic [DM_CNT_W-1:0]   w_cnt_next;
  logic [ADDR_W-1:0]     r_addr;
  logic [WIDTH-1:0]      r_wdata;
  logic                  r_is_wr;
  logic                  r_ready;
  logic                  r_err;

  logic                  w_one;
  logic                  w_both;
  logic                  w_cap;
  logic                  w_err_set;
  logic                  w_acc;
  logic [ADDR_W-1:0]     w_mem_addr;
  logic [WIDTH-1:0]      w_mem_din;
  logic                  w_mem_wr;
  logic                  w_we;
  logic                  w_re;

  assign w_one  = memRead ^ memWrite;
  assign w_both = memRead & memWrite;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state, counter and access-strobe logic.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_cap      = 1'b0;
    w_err_set  = 1'b0;
    w_acc      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_one) begin
          w_cap = 1'b1;
          if (LATENCY == 0) begin
            w_next = RESP;
            w_acc  = 1'b1;
          end else begin
            w_next     = BUSY;
            w_cnt_next = DM_CNT_W'(LATENCY);
          end
        end else if (w_both) begin
          w_err_set = 1'b1;
        end
      end
      BUSY: begin
        if (r_cnt == DM_CNT_W'(1)) begin
          w_next = RESP;
          w_acc  = 1'b1;
        end else begin
          w_cnt_next = r_cnt - DM_CNT_W'(1);
        end
      end
      RESP: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Request capture and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_cap) begin
        r_addr  <= addr;
        r_wdata <= wrData;
        r_is_wr <= memWrite;
      end
      r_ready <= (w_next == RESP);
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  // With zero wait states the access fires straight from IDLE, before the
  // capture registers are loaded, so take the live request in that case.
  always_comb begin
    w_mem_addr = r_addr;
    w_mem_din  = r_wdata;
    w_mem_wr   = r_is_wr;
    if (r_state == IDLE) begin
      w_mem_addr = addr;
      w_mem_din  = wrData;
      w_mem_wr   = memWrite;
    end
  end

  assign w_we = w_acc & w_mem_wr;
  assign w_re = w_acc & ~w_mem_wr;

  dm_array #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (w_we),
    .re   (w_re),
    .addr (w_mem_addr),
    .din  (w_mem_din),
    .dout (rdData)
  );

  // Stall is held low while reset is asserted even if strobes are high.
  assign stall = rst & (((r_state == IDLE) & w_one) | (r_state == BUSY));
  assign ready = r_ready;
  assign err   = r_err;

endmodule : dm_responder

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one instance with LATENCY=2, one with
// LATENCY=0, sharing clock and reset.
module tb_dm_responder;

  logic       clk = 1'b0;
  logic       rst;

  logic       rd2, wr2, rdy2, stl2, err2;
  logic [7:0] a2, d2, q2;
  logic       rd0, wr0, rdy0, stl0, err0;
  logic [7:0] a0, d0, q0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dm_responder #(.WIDTH(8), .ADDR_W(8), .LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .memRead(rd2), .memWrite(wr2), .addr(a2),
    .wrData(d2), .rdData(q2), .ready(rdy2), .stall(stl2), .err(err2)
  );

  dm_responder #(.WIDTH(8), .ADDR_W(8), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .memRead(rd0), .memWrite(wr0), .addr(a0),
    .wrData(d0), .rdData(q0), .ready(rdy0), .stall(stl0), .err(err0)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full access on the LATENCY=2 instance: stall 3 cycles, then ready.
  task automatic acc2(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] exp_q, input string tag);
    wr2 = w; rd2 = !w; a2 = a; d2 = d;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1({tag, "_stall"}, stl2, 1'b1);
      chk1({tag, "_noready"}, rdy2, 1'b0);
      step();
    end
    #1;
    chk1({tag, "_ready"}, rdy2, 1'b1);
    chk1({tag, "_stall_resp"}, stl2, 1'b0);
    chk8({tag, "_rdData"}, q2, exp_q);
    step();
    rd2 = 1'b0; wr2 = 1'b0;
  endtask

  // Full access on the LATENCY=0 instance: stall 1 cycle, then ready.
  task automatic acc0(input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] exp_q, input string tag);
    wr0 = w; rd0 = !w; a0 = a; d0 = d;
    #1;
    chk1({tag, "_stall"}, stl0, 1'b1);
    chk1({tag, "_noready"}, rdy0, 1'b0);
    step();
    #1;
    chk1({tag, "_ready"}, rdy0, 1'b1);
    chk1({tag, "_stall_resp"}, stl0, 1'b0);
    chk8({tag, "_rdData"}, q0, exp_q);
    step();
    rd0 = 1'b0; wr0 = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    rd2 = 1'b0; wr2 = 1'b0; a2 = 8'h00; d2 = 8'h00;
    rd0 = 1'b0; wr0 = 1'b0; a0 = 8'h00; d0 = 8'h00;

    // Reset held with strobes toggling (including both-high).
    for (int i = 0; i < 4; i++) begin
      rd2 = i[0]; wr2 = i[1]; rd0 = i[1]; wr0 = i[0];
      a2 = 8'(i); a0 = 8'(i);
      step();
      #1;
      chk1("rst_ready2", rdy2, 1'b0);
      chk1("rst_stall2", stl2, 1'b0);
      chk8("rst_rdData2", q2, 8'h00);
      chk1("rst_err2", err2, 1'b0);
      chk1("rst_stall0", stl0, 1'b0);
      chk1("rst_ready0", rdy0, 1'b0);
    end
    rd2 = 1'b0; wr2 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
    step();
    rst = 1'b1;
    step();
    #1;
    chk1("idle_stall2", stl2, 1'b0);
    chk1("idle_err2", err2, 1'b0);

    // LATENCY=0: two writes then reads of both addresses.
    acc0(1'b1, 8'h03, 8'h01, 8'h00, "l0_wr3");
    acc0(1'b1, 8'h04, 8'h02, 8'h00, "l0_wr4");
    acc0(1'b0, 8'h03, 8'h00, 8'h01, "l0_rd3");
    acc0(1'b0, 8'h04, 8'h00, 8'h02, "l0_rd4");

    // LATENCY=2: write then read back.
    acc2(1'b1, 8'h10, 8'hA5, 8'h00, "l2_wr10");
    acc2(1'b0, 8'h10, 8'h00, 8'hA5, "l2_rd10");
    acc2(1'b1, 8'h12, 8'h55, 8'hA5, "l2_wr12");

    // Inputs change during BUSY; captured address/data must be used.
    wr2 = 1'b1; a2 = 8'h11; d2 = 8'h3C;
    #1; chk1("cap_stall_t", stl2, 1'b1);
    step();
    a2 = 8'h12; d2 = 8'hFF;
    #1; chk1("cap_stall_t1", stl2, 1'b1);
    step();
    #1; chk1("cap_stall_t2", stl2, 1'b1);
    step();
    #1; chk1("cap_ready", rdy2, 1'b1);
    step();
    wr2 = 1'b0;
    acc2(1'b0, 8'h11, 8'h00, 8'h3C, "cap_rd11");
    acc2(1'b0, 8'h12, 8'h00, 8'h55, "cap_rd12");

    // Both strobes: err set and sticky, no access, no stall.
    acc2(1'b1, 8'h20, 8'h9A, 8'h55, "err_pre");
    rd2 = 1'b1; wr2 = 1'b1; a2 = 8'h20; d2 = 8'h00;
    #1;
    chk1("both_stall", stl2, 1'b0);
    chk1("both_err_pre", err2, 1'b0);
    step();
    #1;
    chk1("both_err", err2, 1'b1);
    chk1("both_stall2", stl2, 1'b0);
    chk1("both_noready", rdy2, 1'b0);
    step();
    #1;
    chk1("both_noready2", rdy2, 1'b0);
    rd2 = 1'b0; wr2 = 1'b0;
    step();
    acc2(1'b0, 8'h20, 8'h00, 8'h9A, "err_rd20");
    #1; chk1("err_sticky", err2, 1'b1);

    // Reset during BUSY of a write: dropped, no ready, err cleared.
    acc2(1'b1, 8'h05, 8'h11, 8'h9A, "rst_pre");
    wr2 = 1'b1; a2 = 8'h05; d2 = 8'h77;
    #1; chk1("mid_stall", stl2, 1'b1);
    step();
    rst = 1'b0;
    #1;
    chk1("mid_noready", rdy2, 1'b0);
    chk1("mid_stall_rst", stl2, 1'b0);
    chk1("mid_err_clr", err2, 1'b0);
    chk8("mid_rdData", q2, 8'h00);
    wr2 = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      chk1("post_noready", rdy2, 1'b0);
    end
    acc2(1'b0, 8'h05, 8'h00, 8'h11, "post_rd05");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_dm_responder
